// File: rtl/bwsram_pkg.sv
// Shared types and helpers for the byte-write SRAM: readback-mode codes,
// sequencer states, per-lane merge and parity.
package bwsram_pkg;

   localparam int RB_NONE = 0;
   localparam int RB_NEW  = 1;
   localparam int RB_OLD  = 2;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       be_b);
      return be_b ? new_b : old_b;
   endfunction

   // Even parity: the stored bit makes the byte plus parity have an even count of ones.
   function automatic logic lane_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/bwsram_if.sv
// Request/response bundle between a bus master (e.g. the APB slave) and bwsram.
// Parity signals exist only when BWSRAM_PARITY_EN is defined.
interface bwsram_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   localparam int NB = DATA_W / 8;

   logic              cs;
   logic              we;
   logic [NB-1:0]     be;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              rvalid;
   logic              init_busy;
`ifdef BWSRAM_PARITY_EN
   logic              par_inj;
   logic [NB-1:0]     par_err;

   modport master (output cs, we, be, addr, din, par_inj,
                   input  dout, rvalid, init_busy, par_err);
   modport slave  (input  cs, we, be, addr, din, par_inj,
                   output dout, rvalid, init_busy, par_err);
`else
   modport master (output cs, we, be, addr, din,
                   input  dout, rvalid, init_busy);
   modport slave  (input  cs, we, be, addr, din,
                   output dout, rvalid, init_busy);
`endif

endinterface

// File: rtl/bwsram_pipe.sv
// Extra output register stage used for two-cycle read latency; data holds while
// invalid, per-lane error flags (BWSRAM_PARITY_EN) are cleared while invalid.
module bwsram_pipe #(
   parameter int DATA_W = 32
`ifdef BWSRAM_PARITY_EN
   , parameter int NB = 4
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
`ifdef BWSRAM_PARITY_EN
   , input  logic [NB-1:0]   perr_i
   , output logic [NB-1:0]   perr_o
`endif
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) data_q <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

`ifdef BWSRAM_PARITY_EN
   logic [NB-1:0] perr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr_q <= '0;
      else        perr_q <= valid_i ? perr_i : '0;
   end

   assign perr_o = perr_q;
`endif

endmodule

// File: rtl/bwsram.sv
// Single-port SRAM with byte enables, 1/2-cycle read latency, write readback and a
// zero-fill sequencer after reset. Optional lane parity via BWSRAM_PARITY_EN.
module bwsram
   import bwsram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1,
   parameter int WR_RB  = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   bwsram_if.slave  bus
);

   localparam int              NB       = DATA_W / 8;
   localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam bit              RB_ON    = (WR_RB != RB_NONE);
   localparam bit              RB_MERGE = (WR_RB == RB_NEW);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             init_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_IDX) begin
            state_d = RUN;
            cnt_d   = '0;
         end
      end
   end

   always_comb begin
      init_busy = (state_q == INIT);
   end

   assign bus.init_busy = init_busy;

   // Request decode; cs is ignored entirely while the sweep runs.
   logic             in_range, run_acc, wr_ok, rd_issue;
   logic [IDX_W-1:0] a_idx;

   assign a_idx    = bus.addr[IDX_W-1:0];
   assign in_range = ({1'b0, bus.addr} < DEPTH_L);
   assign run_acc  = (state_q == RUN) && bus.cs;
   assign wr_ok    = run_acc && bus.we && in_range;
   assign rd_issue = run_acc && (!bus.we || RB_ON);

   logic             mem_we;
   logic [IDX_W-1:0] w_idx;
   logic [DATA_W-1:0] w_data;
   logic [NB-1:0]    w_be;

   assign mem_we = init_busy || wr_ok;
   assign w_idx  = init_busy ? cnt_q : a_idx;
   assign w_data = init_busy ? '0 : bus.din;
   assign w_be   = init_busy ? '1 : bus.be;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
         end
      end
   end

   logic [DATA_W-1:0] old_word, new_word, rb_word;

   assign old_word = mem[a_idx];

   for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign new_word[8*gi +: 8] = merge_byte(old_word[8*gi +: 8], bus.din[8*gi +: 8], bus.be[gi]);
   end

   // Out-of-range accesses return zero; write-first returns the merged word.
   assign rb_word = !in_range                ? '0       :
                    (bus.we && RB_MERGE)     ? new_word : old_word;

   logic              s1_valid_q;
   logic [DATA_W-1:0] s1_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= rd_issue;
         if (rd_issue) s1_data_q <= rb_word;
      end
   end

`ifdef BWSRAM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] old_par, w_par, new_par, rb_par, rb_err, s1_perr_q, perr_w;

   assign old_par = par_mem[a_idx];

   for (genvar gi = 0; gi < NB; gi++) begin : g_par
      assign w_par[gi]   = init_busy ? 1'b0 : (lane_parity(bus.din[8*gi +: 8]) ^ bus.par_inj);
      assign new_par[gi] = bus.be[gi] ? w_par[gi] : old_par[gi];
      assign rb_err[gi]  = in_range && (lane_parity(rb_word[8*gi +: 8]) ^ rb_par[gi]);
   end

   assign rb_par = (bus.we && RB_MERGE) ? new_par : old_par;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) par_mem[w_idx][i] <= w_par[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_perr_q <= '0;
      else        s1_perr_q <= rd_issue ? rb_err : '0;
   end

   assign bus.par_err = perr_w;
`endif

   logic              valid_w;
   logic [DATA_W-1:0] dout_w;

   if (RD_LAT == 2) begin : g_lat2
      bwsram_pipe #(
         .DATA_W (DATA_W)
`ifdef BWSRAM_PARITY_EN
         , .NB   (NB)
`endif
      ) u_pipe (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid_i (s1_valid_q),
         .data_i  (s1_data_q),
         .valid_o (valid_w),
         .data_o  (dout_w)
`ifdef BWSRAM_PARITY_EN
         , .perr_i (s1_perr_q)
         , .perr_o (perr_w)
`endif
      );
   end else begin : g_lat1
      assign valid_w = s1_valid_q;
      assign dout_w  = s1_data_q;
`ifdef BWSRAM_PARITY_EN
      assign perr_w  = s1_perr_q;
`endif
   end

   assign bus.rvalid = valid_w;
   assign bus.dout   = dout_w;

endmodule
